// File: rtl/nibble_fetch.sv
// nibble_fetch: fetch stage behind the nibble-wide memory.
// Walks a nibble program counter, packs each run of NIBS returned nibbles
// into one word (first nibble in the top bits) and offers it to the decoder
// over valid/ready. A jump redirects the stream and throws away any partial word.
// Optional build macro NIBBLE_FETCH_OVERLAP_EN adds a separate output register
// so the next word is assembled while the previous one waits for the consumer.
module nibble_fetch #(
    parameter int ADDR_W = 16,
    parameter int NIB_W  = 4,
    parameter int NIBS   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [NIB_W-1:0]        mem_data,
    input  logic                    start,
    input  logic                    halt,
    input  logic                    jump_valid,
    input  logic [ADDR_W-1:0]       jump_addr,
    output logic [NIB_W*NIBS-1:0]   word,
    output logic [ADDR_W-1:0]       word_addr,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    busy
);
    localparam int WORD_W = NIB_W * NIBS;
    localparam int CNT_W  = $clog2(NIBS + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NIBS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   pc_r, pc_s;
    logic [ADDR_W-1:0]   first_addr_r, first_addr_s;
    logic [WORD_W-1:0]   asm_r, asm_s;
    logic [CNT_W-1:0]    issue_cnt_r, issue_cnt_s;
    logic [CNT_W-1:0]    cap_cnt_r, cap_cnt_s;
    logic                cap_pend_r, cap_pend_s;
    logic [WORD_W-1:0]   word_r, word_s;
    logic [ADDR_W-1:0]   word_addr_r, word_addr_s;
    logic                word_valid_r, word_valid_s;
    logic                busy_r;
    logic [WORD_W-1:0]   shift_s;

    // The nibble returned this cycle always enters at the bottom of the assembly.
    assign shift_s = {asm_r[WORD_W-NIB_W-1:0], mem_data};

`ifdef NIBBLE_FETCH_OVERLAP_EN
    logic out_free_s, asm_full_s, done_s, halting_s, stall_s;
    // Output register can take a word this edge if empty or being consumed.
    assign out_free_s = ~word_valid_r | word_ready;
    assign asm_full_s = (cap_cnt_r == CNT_FULL);
    assign done_s     = cap_pend_r & (cap_cnt_r == CNT_LAST);
    // Halt only stops issue at a word boundary so no partial word is left behind.
    assign halting_s  = halt & (issue_cnt_r == CNT_ZERO);
    // Stop issuing when a finished assembly has nowhere to go; otherwise the
    // nibble in flight would land on top of it.
    assign stall_s    = (asm_full_s | done_s) & ~out_free_s;
`endif

    // Next-state and datapath decisions; a jump overrides everything else.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        first_addr_s = first_addr_r;
        asm_s        = asm_r;
        issue_cnt_s  = issue_cnt_r;
        cap_cnt_s    = cap_cnt_r;
        cap_pend_s   = 1'b0;
        word_s       = word_r;
        word_addr_s  = word_addr_r;
        word_valid_s = word_valid_r;
        if (jump_valid) begin
            // Discard the partial word and the nibble in flight, restart at the target.
            pc_s         = jump_addr;
            state_s      = ST_FILL;
            asm_s        = {WORD_W{1'b0}};
            issue_cnt_s  = CNT_ZERO;
            cap_cnt_s    = CNT_ZERO;
            cap_pend_s   = 1'b0;
            word_valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = ST_FILL;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
`ifdef NIBBLE_FETCH_OVERLAP_EN
                ST_FILL, ST_OUT: begin
                    if (word_valid_r && word_ready) begin
                        word_valid_s = 1'b0;
                    end else begin
                        word_valid_s = word_valid_r;
                    end
                    if (asm_full_s && out_free_s) begin
                        word_s       = asm_r;
                        word_addr_s  = first_addr_r;
                        word_valid_s = 1'b1;
                        cap_cnt_s    = CNT_ZERO;
                    end else if (cap_pend_r) begin
                        asm_s = shift_s;
                        if (done_s && out_free_s) begin
                            word_s       = shift_s;
                            word_addr_s  = first_addr_r;
                            word_valid_s = 1'b1;
                            cap_cnt_s    = CNT_ZERO;
                        end else begin
                            cap_cnt_s = cap_cnt_r + CNT_ONE;
                        end
                    end else begin
                        cap_cnt_s = cap_cnt_r;
                    end
                    if (!stall_s && !halting_s) begin
                        if (issue_cnt_r == CNT_ZERO) begin
                            first_addr_s = pc_r;
                        end else begin
                            first_addr_s = first_addr_r;
                        end
                        pc_s        = pc_r + ADDR_W'(1);
                        issue_cnt_s = (issue_cnt_r == CNT_LAST) ? CNT_ZERO : issue_cnt_r + CNT_ONE;
                        cap_pend_s  = 1'b1;
                    end else begin
                        cap_pend_s = 1'b0;
                    end
                    if (halting_s && !cap_pend_r && (cap_cnt_r == CNT_ZERO) && out_free_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_FILL;
                    end
                end
`else
                ST_FILL: begin
                    if (issue_cnt_r < CNT_FULL) begin
                        if (issue_cnt_r == CNT_ZERO) begin
                            first_addr_s = pc_r;
                        end else begin
                            first_addr_s = first_addr_r;
                        end
                        pc_s        = pc_r + ADDR_W'(1);
                        issue_cnt_s = issue_cnt_r + CNT_ONE;
                        cap_pend_s  = 1'b1;
                    end else begin
                        cap_pend_s = 1'b0;
                    end
                    if (cap_pend_r) begin
                        asm_s     = shift_s;
                        cap_cnt_s = cap_cnt_r + CNT_ONE;
                        if (cap_cnt_r == CNT_LAST) begin
                            word_s       = shift_s;
                            word_addr_s  = first_addr_r;
                            word_valid_s = 1'b1;
                            state_s      = ST_OUT;
                        end else begin
                            state_s = ST_FILL;
                        end
                    end else begin
                        state_s = ST_FILL;
                    end
                end
                ST_OUT: begin
                    if (word_valid_r && word_ready) begin
                        word_valid_s = 1'b0;
                        issue_cnt_s  = CNT_ZERO;
                        cap_cnt_s    = CNT_ZERO;
                        state_s      = halt ? ST_IDLE : ST_FILL;
                    end else begin
                        state_s = ST_OUT;
                    end
                end
`endif
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pc_r         <= {ADDR_W{1'b0}};
            first_addr_r <= {ADDR_W{1'b0}};
            asm_r        <= {WORD_W{1'b0}};
            issue_cnt_r  <= CNT_ZERO;
            cap_cnt_r    <= CNT_ZERO;
            cap_pend_r   <= 1'b0;
            word_r       <= {WORD_W{1'b0}};
            word_addr_r  <= {ADDR_W{1'b0}};
            word_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            first_addr_r <= first_addr_s;
            asm_r        <= asm_s;
            issue_cnt_r  <= issue_cnt_s;
            cap_cnt_r    <= cap_cnt_s;
            cap_pend_r   <= cap_pend_s;
            word_r       <= word_s;
            word_addr_r  <= word_addr_s;
            word_valid_r <= word_valid_s;
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    // The memory address is the pc register itself, so it holds pc whenever issue pauses.
    assign mem_addr   = pc_r;
    assign word       = word_r;
    assign word_addr  = word_addr_r;
    assign word_valid = word_valid_r;
    assign busy       = busy_r;
endmodule

// File: doc/nibble_fetch.md
Name: nibble_fetch

Overview:
- Fetch stage directly downstream of the nibble-wide `memory` block.
- Drives the 16-bit nibble address into `memory`.
- Collects the returned 4-bit nibbles and packs each run of 8 into one 32-bit instruction word.
- Hands each word to the decoder over a valid/ready handshake; supports redirect (jump) from the execute stage.

Parameters:
- ADDR_W, 16, nibble address width; matches the `memory` address port.
- NIB_W, 4, nibble width; matches the `memory` data port.
- NIBS, 8, nibbles per output word; word width is NIB_W*NIBS = 32.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- mem_addr  out  ADDR_W  nibble address to `memory`.
- mem_data  in  NIB_W  nibble from `memory`; the value for address A is valid the cycle after mem_addr==A was sampled at posedge.
- start  in  1  one-cycle pulse; leaves IDLE and fetches from the current pc.
- halt  in  1  level; return to IDLE at the next word boundary.
- jump_valid  in  1  redirect request.
- jump_addr  in  ADDR_W  redirect target.
- word  out  32  packed word; the first-fetched nibble sits in bits [31:28].
- word_addr  out  ADDR_W  address of the word's first nibble.
- word_valid  out  1  word/word_addr valid.
- word_ready  in  1  consumer accepts.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0) clears:
  - state=IDLE, pc=0, mem_addr=0, word=0, word_addr=0, word_valid=0, busy=0.
  - issue count and capture count = 0.
- States: IDLE, FILL, OUT.
- IDLE:
  - mem_addr holds pc.
  - start=1 -> FILL.
  - jump_valid=1 -> pc<=jump_addr, then FILL.
- FILL:
  - Issue: each cycle with issue count < NIBS, present mem_addr=pc, then pc<=pc+1 and issue count +1.
  - Capture: the cycle after each issue, shift mem_data into the assembly register, new nibble entering at [3:0].
  - After the 8th capture: word, word_addr and word_valid=1 are registered together -> OUT.
  - Latency: 9 clocks from the first issue to word_valid high.
  - word_addr = pc value at the first issue.
- OUT:
  - word, word_addr and word_valid are held stable until word_valid & word_ready.
  - On handshake: word_valid<=0 and both counts clear.
  - Then FILL if halt=0, else IDLE.
  - The post-handshake transition is taken at the clock edge that completes the handshake.
- pc arithmetic is modulo 2^ADDR_W: 0xFFFF+1 = 0x0000. A word may straddle the wrap; word_addr is then the pre-wrap address.
- jump_valid in FILL or OUT (highest priority):
  - Assembly is discarded and both counts clear.
  - The nibble in flight is ignored and is not captured.
  - pc<=jump_addr, state<=FILL, word_valid<=0.
  - If word_valid & word_ready hold in the same cycle, that word counts as consumed; the jump still takes effect.
- halt in FILL: the current word completes and is handshaken, then -> IDLE.
- start while not IDLE: ignored.
- start and jump_valid together in IDLE: jump wins.
- rst_n asserted mid-word: immediate clear to the reset values above; no partial word is ever presented.

Optional Feature:
- Macro: NIBBLE_FETCH_OVERLAP_EN.
- Defined:
  - A separate output register is added.
  - FILL continues assembling the next word while OUT holds the previous one.
  - A completed assembly moves to the output register on the same edge as the handshake or when the output register is empty.
  - Issue stalls, with mem_addr held, only when assembly is full and the output register is occupied.
  - With word_ready held high, word_valid stays high continuously and a new word is presented every 8 clocks.
  - Jump flushes both registers.
- Undefined: behaviour exactly as above; ≥10 clocks per word.

Test Plan:
- Memory preloaded with nibble[A]=A[3:0]; reset, start, word_ready=1 -> first word=0x01234567, word_addr=0x0000, word_valid rises 9 clocks after first issue; second word=0x89ABCDEF, word_addr=0x0008.
- word_ready held low 20 clocks after first word -> word/word_addr stable, mem_addr frozen at 0x0008, no extra captures; release -> second word still 0x89ABCDEF.
- jump_valid with jump_addr=0x0100 during the 5th nibble of a word -> partial discarded, next word_addr=0x0100, word=0x01234567.
- jump_addr=0xFFFC, then fetch -> word=0xCDEF0123, word_addr=0xFFFC, pc continues at 0x0004.
- rst_n pulsed low during FILL after 3 nibbles -> all outputs 0 on the same cycle, state IDLE, no word_valid until the next start.
- Under NIBBLE_FETCH_OVERLAP_EN, word_ready=1, 64 clocks -> 8 words, word_valid continuously high after the first, consecutive word_addr step 8.
